regfile_wb_scheduler: RTL
=========================

# regfile_wb_scheduler

Writeback scheduler for the 32-entry register file of the RISC-V core. Shares the register file's single write port between two writeback sources, exec/ALU (requester 0) and load unit (requester 1), using round-robin arbitration and a registered write stage. Keeps a per-register pending-write scoreboard that the issue stage queries for RAW hazards and write-count overflow. Sits between the execute/memory units and the register file, driving its write port directly.

## Interface

- REG_NUM_BITWIDTH, 5, register index width
- WORD_BITWIDTH, 32, data word width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction with destination issued this cycle
- issue_rd  in  REG_NUM_BITWIDTH  destination of issuing instruction
- issue_ready  out  1  issue permitted (destination counter not saturated)
- check_rs1, check_rs2  in  REG_NUM_BITWIDTH  source registers of instruction in decode
- hazard  out  1  either source has a pending write
- req0_valid, req1_valid  in  1  writeback request
- req0_rd, req1_rd  in  REG_NUM_BITWIDTH  writeback destination
- req0_data, req1_data  in  WORD_BITWIDTH  writeback data
- req0_ready, req1_ready  out  1  request accepted this cycle
- doRegWrite  out  1  register-file write enable
- regToWrite  out  REG_NUM_BITWIDTH  register-file write index
- write_data  out  WORD_BITWIDTH  register-file write data

## Operation

- Scoreboard: one 2-bit pending counter per register 1..31; x0 has none and always reads 0.
- issue_ready = (issue_rd == 0) or count[issue_rd] != 3. Issue with issue_valid & issue_ready and rd != 0 increments count[issue_rd]. issue_valid while issue_ready is 0 is ignored.
- Counter decrement occurs on a cycle with doRegWrite = 1, for count[regToWrite].
- Increment and decrement of the same register in one cycle leave the count unchanged.
- Decrement at count 0 is a protocol error; the counter holds at 0.
- hazard = (check_rs1 != 0 and count[check_rs1] != 0) or (check_rs2 != 0 and count[check_rs2] != 0). Combinational from counter state.
  - Not bypassed by same-cycle issue or writeback.
- Arbitration: at most one grant per cycle, with a 1-bit last_grant pointer.
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant updates to the granted index on each grant.
- reqN_ready is combinational from both valids and last_grant, and is asserted only with reqN_valid.
- Requesters hold valid, rd and data stable until ready. Dropping valid before ready is allowed; nothing is written.
- An accepted request loads the write stage.
  - Next cycle: doRegWrite = 1, regToWrite = rd, write_data = data.
  - Exception: accepted rd == 0 is consumed with doRegWrite = 0 and does not touch the scoreboard.
- With no grant, doRegWrite = 0 next cycle; regToWrite and write_data hold their last values.

## Timing

- Reset values: doRegWrite 0, regToWrite 0, write_data 0, all counters 0, last_grant 1 (requester 0 wins the first contention).
- Reset outputs: issue_ready 1, hazard 0, reqN_ready follows valids.
- Grant to write-port latency: 1 cycle. Sustained throughput: one write per cycle.
- Write to counter clear: count decrements at the same edge that ends the doRegWrite cycle. hazard drops the cycle after doRegWrite.
- Reset mid-operation: an in-flight write-stage entry is discarded and counters are cleared. Requesters and issue must re-present after reset.

## Structure

- Shared package `regfile_pkg`:
  - REG_NUM_BITWIDTH, WORD_BITWIDTH, NUM_REGS = 32.
  - PEND_CNT_W = 2, PEND_CNT_MAX = 3.
  - Requester index constants REQ_EXEC = 0, REQ_LOAD = 1.
- Sub-module `rr_arb2`: two-requester round-robin arbiter holding last_grant. Outputs a one-hot grant.
- The scoreboard and the write stage live in the top.

## Test plan

- Reset, then req0 only (rd = 5, data = 0xDEADBEEF) → req0_ready same cycle. Next cycle doRegWrite = 1, regToWrite = 5, write_data = 0xDEADBEEF.
- Both valid for 4 cycles (rd 3 and 4) → grant order 0, 1, 0, 1. Writes appear 1 cycle later in the same order.
- Issue rd = 7 three times → issue_ready = 0 for rd 7, and a fourth issue is ignored. check_rs1 = 7 → hazard = 1 until the third writeback to 7, then 0 the following cycle.
- Same-cycle issue rd = 9 and doRegWrite to 9 with count 1 → count stays 1 and hazard stays 1.
- Write request with rd = 0 → accepted with doRegWrite = 0. check_rs2 = 0 → hazard = 0 always.
- Assert rst while the write stage holds rd = 12 and count[12] = 2 → doRegWrite = 0 immediately, counters 0, hazard 0, last_grant 1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, types and helpers for the register-file
//               writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_NUM_BITWIDTH = 5;
    localparam int WORD_BITWIDTH    = 32;
    localparam int NUM_REGS         = 32;

    localparam int PEND_CNT_W = 2;
    localparam logic [PEND_CNT_W-1:0] PEND_CNT_MAX = 2'd3;

    localparam int REQ_EXEC = 0;
    localparam int REQ_LOAD = 1;

    typedef logic [REG_NUM_BITWIDTH-1:0] reg_idx_t;
    typedef logic [WORD_BITWIDTH-1:0]    word_t;
    typedef logic [PEND_CNT_W-1:0]       pend_cnt_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        word_t    data;
    } wb_req_t;

    // Simultaneous issue and retire of the same register cancel out;
    // a retire against an empty counter is a protocol error and saturates at 0.
    function automatic pend_cnt_t next_count(pend_cnt_t cur, logic inc, logic dec);
        pend_cnt_t res;
        res = cur;
        if (inc && !dec) begin
            res = cur + pend_cnt_t'(1);
        end else if (dec && !inc && (cur != '0)) begin
            res = cur - pend_cnt_t'(1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler_if
// Description : Issue, hazard-query, writeback-request and register-file write
//               port signals of the writeback scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if;
    import regfile_pkg::*;

    logic     issue_valid;
    reg_idx_t issue_rd;
    logic     issue_ready;

    reg_idx_t check_rs1;
    reg_idx_t check_rs2;
    logic     hazard;

    logic     req0_valid;
    reg_idx_t req0_rd;
    word_t    req0_data;
    logic     req0_ready;

    logic     req1_valid;
    reg_idx_t req1_rd;
    word_t    req1_data;
    logic     req1_ready;

    logic     doRegWrite;
    reg_idx_t regToWrite;
    word_t    write_data;

    modport slave (
        input  issue_valid, issue_rd, check_rs1, check_rs2,
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output issue_ready, hazard, req0_ready, req1_ready,
        output doRegWrite, regToWrite, write_data
    );

    modport master (
        output issue_valid, issue_rd, check_rs1, check_rs2,
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  issue_ready, hazard, req0_ready, req1_ready,
        input  doRegWrite, regToWrite, write_data
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter with a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import regfile_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_o        = 2'b00;
        last_grant_d = last_grant_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // On contention the requester that did not win last time goes first.
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o != 2'b00) begin
            last_grant_d = gnt_o[REQ_LOAD];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Shares the register-file write port between exec and load
//               writebacks and tracks pending writes per register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_wb_scheduler_if.slave wb
);

    logic [1:0] req_vld;
    logic [1:0] gnt;
    wb_req_t    sel_req;

    logic       wr_en_q,   wr_en_d;
    reg_idx_t   wr_rd_q,   wr_rd_d;
    word_t      wr_data_q, wr_data_d;

    pend_cnt_t  cnt_q [NUM_REGS];
    pend_cnt_t  cnt_d [NUM_REGS];
    logic       issue_fire;

    assign req_vld = {wb.req1_valid, wb.req0_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_vld),
        .gnt_o (gnt)
    );

    assign wb.req0_ready = gnt[REQ_EXEC];
    assign wb.req1_ready = gnt[REQ_LOAD];

    always_comb begin
        sel_req = '0;
        if (gnt[REQ_LOAD]) begin
            sel_req = '{valid: 1'b1, rd: wb.req1_rd, data: wb.req1_data};
        end else if (gnt[REQ_EXEC]) begin
            sel_req = '{valid: 1'b1, rd: wb.req0_rd, data: wb.req0_data};
        end
    end

    // A granted write to x0 is swallowed here: no write, no scoreboard effect.
    always_comb begin
        wr_en_d   = sel_req.valid && (sel_req.rd != '0);
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_rd_d   = sel_req.rd;
            wr_data_d = sel_req.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wb.doRegWrite = wr_en_q;
    assign wb.regToWrite = wr_rd_q;
    assign wb.write_data = wr_data_q;

    assign wb.issue_ready = (wb.issue_rd == '0) || (cnt_q[wb.issue_rd] != PEND_CNT_MAX);
    assign issue_fire     = wb.issue_valid && wb.issue_ready && (wb.issue_rd != '0);

    // The retire side uses the write stage itself, so a counter drops at the
    // edge that closes its doRegWrite cycle.
    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = next_count(cnt_q[i],
                                  issue_fire && (wb.issue_rd == reg_idx_t'(i)),
                                  wr_en_q && (wr_rd_q == reg_idx_t'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign wb.hazard = ((wb.check_rs1 != '0) && (cnt_q[wb.check_rs1] != '0)) ||
                       ((wb.check_rs2 != '0) && (cnt_q[wb.check_rs2] != '0));

endmodule
`default_nettype wire
